// File: rtl/data_mem_responder.sv
// Byte-addressed data memory that serves a processor port (fixed read latency,
// one-cycle write ack) and a host port that owns the memory while host_mode is high.
module data_mem_responder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              busy,
  output logic              err,
  input  logic              host_mode,
  output logic              host_ready,
  input  logic              host_we,
  input  logic              host_re,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ACK} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_start;
  logic              wr_start;
  logic              rd_done;
  logic              err_set;
  logic              host_wr;
  logic              host_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  assign busy       = (state != IDLE);
  assign host_ready = host_mode && (state == IDLE);
  assign host_wr    = host_ready && host_we;
  assign host_rd    = host_ready && host_re && !host_we;

  // Processor and host writes are mutually exclusive: both require IDLE, split by host_mode.
  assign mem_we    = wr_start || host_wr;
  assign mem_waddr = host_wr ? host_addr : addr_in;
  assign mem_wdata = host_wr ? host_wdata : din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_start   = 1'b0;
    wr_start   = 1'b0;
    rd_done    = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (!host_mode) begin
          if (read) begin
            rd_start   = 1'b1;
            err_set    = write;
            state_next = RD_WAIT;
          end else if (write) begin
            wr_start   = 1'b1;
            state_next = WR_ACK;
          end
        end
      end
      RD_WAIT: begin
        err_set = read || write;
        if (cnt == 4'd0) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end
      end
      WR_ACK: begin
        err_set    = read || write;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rd_addr     <= '0;
      dout        <= '0;
      rd_valid    <= 1'b0;
      err         <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      rd_valid    <= rd_done;
      host_rvalid <= host_rd;
      if (err_set) err <= 1'b1;
      if (rd_start) begin
        rd_addr <= addr_in;
        cnt     <= LAT_LOAD;
      end else if (state == RD_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (rd_done) dout <= mem[rd_addr];
      if (host_rd) host_rdata <= mem[host_addr];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected read data is queued when a
// read is issued and compared when rd_valid / host_rvalid fire.
module tb_data_mem_responder;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [ADDR_W-1:0] addr_in = '0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] dout;
  logic              rd_valid;
  logic              busy;
  logic              err;
  logic              host_mode = 1'b0;
  logic              host_ready;
  logic              host_we = 1'b0;
  logic              host_re = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [DATA_W-1:0] rd_q[$];
  logic [DATA_W-1:0] host_q[$];
  logic [DATA_W-1:0] mon_rd_exp;
  logic [DATA_W-1:0] mon_host_exp;

  data_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr_in(addr_in), .din(din),
    .dout(dout), .rd_valid(rd_valid), .busy(busy), .err(err),
    .host_mode(host_mode), .host_ready(host_ready), .host_we(host_we), .host_re(host_re),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Output monitor: sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rd_valid) begin
      if (rd_q.size() == 0) check("rd_unexpected", rd_valid, 1'b0);
      else begin
        mon_rd_exp = rd_q.pop_front();
        $display("proc read  -> dout=0x%02h (exp 0x%02h)", dout, mon_rd_exp);
        check("rd_data", dout, mon_rd_exp);
      end
    end
    if (host_rvalid) begin
      if (host_q.size() == 0) check("host_unexpected", host_rvalid, 1'b0);
      else begin
        mon_host_exp = host_q.pop_front();
        $display("host read  -> rdata=0x%02h (exp 0x%02h)", host_rdata, mon_host_exp);
        check("host_data", host_rdata, mon_host_exp);
      end
    end
  end

  task automatic wait_idle(input string tag, input int exp_cycles);
    int n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, exp_cycles);
  endtask

  task automatic proc_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    @(negedge clk);
    read = 1'b1; addr_in = a; rd_q.push_back(e);
    @(negedge clk);
    read = 1'b0;
    wait_idle("rd_busy_cycles", RD_LAT);
    @(negedge clk);
    check("dout_hold", dout, e);
  endtask

  task automatic proc_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    write = 1'b1; addr_in = a; din = d;
    @(negedge clk);
    write = 1'b0;
    $display("proc write addr=0x%04h data=0x%02h", a, d);
    wait_idle("wr_busy_cycles", 1);
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    check("host_ready_wr", host_ready, 1'b1);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    $display("host write addr=0x%04h data=0x%02h", a, d);
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    @(negedge clk);
    host_re = 1'b1; host_addr = a; host_q.push_back(e);
    @(negedge clk);
    host_re = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 rst = 1'b1;
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_host_rdata", host_rdata, 8'h00);
    check("rst_host_rvalid", host_rvalid, 1'b0);
    check("rst_host_ready", host_ready, 1'b0);
    @(negedge clk) rst = 1'b0;

    // Host preload, then processor read with RD_LAT latency
    @(negedge clk) host_mode = 1'b1;
    host_write(16'h0010, 8'hA5);
    host_read(16'h0010, 8'hA5);
    @(negedge clk) host_mode = 1'b0;
    proc_read(16'h0010, 8'hA5);

    // Top address and no aliasing with address 0
    proc_write(16'hFFFF, 8'h3C);
    proc_read(16'hFFFF, 8'h3C);
    proc_write(16'h0000, 8'h5A);
    proc_read(16'hFFFF, 8'h3C);
    proc_read(16'h0000, 8'h5A);
    check("err_clean", err, 1'b0);

    // Simultaneous read and write: read wins, write dropped, err set
    proc_write(16'h0001, 8'h11);
    @(negedge clk);
    read = 1'b1; write = 1'b1; addr_in = 16'h0001; din = 8'h22; rd_q.push_back(8'h11);
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    wait_idle("rw_busy_cycles", RD_LAT);
    check("rw_err", err, 1'b1);
    proc_read(16'h0001, 8'h11);
    @(negedge clk) rst = 1'b1;
    #1 check("err_cleared_by_rst", err, 1'b0);
    @(negedge clk) rst = 1'b0;

    // Second strobe during RD_WAIT is ignored and flags err
    @(negedge clk);
    read = 1'b1; addr_in = 16'h0010; rd_q.push_back(8'hA5);
    @(negedge clk);
    addr_in = 16'hFFFF;
    @(negedge clk);
    read = 1'b0;
    wait_idle("rd2_busy_cycles", RD_LAT - 1);
    check("rd2_err", err, 1'b1);
    proc_read(16'h0000, 8'h5A);
    check("err_sticky", err, 1'b1);

    // Asynchronous reset mid-read aborts it
    @(negedge clk);
    read = 1'b1; addr_in = 16'hFFFF;
    @(negedge clk);
    read = 1'b0;
    check("busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_dout", dout, 8'h00);
    check("arst_rd_valid", rd_valid, 1'b0);
    check("arst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    proc_read(16'hFFFF, 8'h3C);
    proc_read(16'h0010, 8'hA5);

    // host_mode raised mid-read: host locked out until the read completes
    @(negedge clk);
    read = 1'b1; addr_in = 16'h0010; rd_q.push_back(8'hA5);
    @(negedge clk);
    read = 1'b0; host_mode = 1'b1;
    host_we = 1'b1; host_addr = 16'h0010; host_wdata = 8'hEE;
    n = 0;
    while (busy && n < 20) begin
      check("host_not_ready", host_ready, 1'b0);
      n++;
      @(negedge clk);
    end
    host_we = 1'b0;
    check("hm_busy_cycles", n, RD_LAT);
    check("host_ready_after", host_ready, 1'b1);
    host_read(16'h0010, 8'hA5);

    // Processor strobes under host ownership: ignored, no err
    @(negedge clk);
    write = 1'b1; addr_in = 16'h0010; din = 8'h00;
    @(negedge clk);
    write = 1'b0;
    check("hm_strobe_busy", busy, 1'b0);
    check("hm_strobe_err", err, 1'b0);

    // Host write and read together: write wins, no rvalid
    @(negedge clk);
    host_we = 1'b1; host_re = 1'b1; host_addr = 16'h0020; host_wdata = 8'h77;
    @(negedge clk);
    host_we = 1'b0; host_re = 1'b0;
    host_read(16'h0020, 8'h77);
    host_read(16'h0010, 8'hA5);
    @(negedge clk) host_mode = 1'b0;
    proc_read(16'h0020, 8'h77);

    repeat (4) @(negedge clk);
    check("rd_q_drained", rd_q.size(), 0);
    check("host_q_drained", host_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL be the address width; memory depth SHALL be 2**ADDR_W bytes.
REQ-002 Parameter DATA_W, default 8, SHALL be the data width.
REQ-003 Parameter RD_LAT, default 2, legal 1..15, SHALL be the read latency in cycles.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-006 read  input  1  SHALL be the processor read strobe.
REQ-007 write  input  1  SHALL be the processor write strobe.
REQ-008 addr_in  input  ADDR_W  SHALL be the processor byte address.
REQ-009 din  input  DATA_W  SHALL be the processor write data.
REQ-010 dout  output  DATA_W  SHALL be the read data returned to the processor.
REQ-011 rd_valid  output  1  SHALL pulse for one cycle when dout carries new read data.
REQ-012 busy  output  1  SHALL be high while a processor transaction is in progress.
REQ-013 err  output  1  SHALL be a sticky protocol-error flag.
REQ-014 host_mode  input  1  SHALL give the host port ownership of memory when high.
REQ-015 host_ready  output  1  SHALL be high when host_mode=1 and the FSM is IDLE.
REQ-016 host_we  input  1  SHALL be the host write enable.
REQ-017 host_re  input  1  SHALL be the host read enable.
REQ-018 host_addr  input  ADDR_W  SHALL be the host address.
REQ-019 host_wdata  input  DATA_W  SHALL be the host write data.
REQ-020 host_rdata  output  DATA_W  SHALL be the host read data.
REQ-021 host_rvalid  output  1  SHALL pulse for one cycle when host_rdata is new.

Function
REQ-022 FSM states SHALL be IDLE, RD_WAIT, WR_ACK; busy=1 in RD_WAIT and WR_ACK only.
REQ-023 IDLE, host_mode=0, read=1 at edge k: latch addr_in, load latency counter, go RD_WAIT.
REQ-024 RD_WAIT: dout<=mem[latched addr] and rd_valid=1 SHALL appear after edge k+RD_LAT, then return to IDLE.
REQ-025 IDLE, host_mode=0, write=1 (read=0) at edge k: mem[addr_in]<=din at edge k, go WR_ACK for exactly one cycle, then IDLE.
REQ-026 read=1 and write=1 together in IDLE: read SHALL be serviced, write discarded, err set.
REQ-027 read or write asserted while busy=1: strobe ignored, err set; memory and in-flight read unaffected.
REQ-028 dout SHALL hold its last value between reads; rd_valid low otherwise.
REQ-029 Read of an address written in an earlier cycle SHALL return the new value.
REQ-030 host_mode=1 asserted mid-transaction: transaction SHALL complete normally; host accesses ignored until host_ready=1.
REQ-031 host_mode=1 and IDLE: processor strobes SHALL be ignored without setting err.
REQ-032 host_ready=1, host_we=1: mem[host_addr]<=host_wdata at that edge.
REQ-033 host_ready=1, host_re=1: host_rdata=mem[host_addr], host_rvalid=1 after the next edge (latency 1); host_we and host_re together: write wins, no rvalid.
REQ-034 Addresses SHALL cover the full 0..2**ADDR_W-1 range with no aliasing.
REQ-035 err SHALL clear only on reset.

Reset
REQ-036 rst=1 SHALL force IDLE, dout=0, rd_valid=0, busy=0, err=0, host_rdata=0, host_rvalid=0 immediately, without clock.
REQ-037 Memory contents SHALL NOT be reset.
REQ-038 Reset during RD_WAIT SHALL abort the read with no rd_valid pulse; a write committed before reset SHALL persist.

Verification
REQ-039 Host writes 0xA5 to 0x0010, host_mode->0, processor read 0x0010 at edge k -> dout=0xA5, rd_valid=1 after edge k+2, busy high 2 cycles.
REQ-040 Processor write 0x3C to 0xFFFF, then read 0xFFFF -> dout=0x3C; busy high one cycle after the write.
REQ-041 read=write=1 at address 0x0001 holding 0x11, din=0x22 -> dout=0x11, mem unchanged, err=1.
REQ-042 Second read strobe during RD_WAIT -> ignored, single rd_valid pulse, err=1.
REQ-043 rst asserted mid-RD_WAIT -> no rd_valid, dout=0, busy=0 asynchronously; prior written data still readable.
REQ-044 host_mode raised during RD_WAIT -> host_ready stays 0 until rd_valid cycle completes; host read 0x0010 then returns 0xA5 with host_rvalid one cycle later.
